// File: rtl/adder_share_arbiter_if.sv
// Request/response bus of the shared-adder arbiter.
//   slave  : arbiter side (takes requests, produces responses)
//   master : requester/consumer side
//   REQ_VALID/REQ_READY : per-requester operand handshake (4 requesters)
//   REQ_X/REQ_Y         : packed operands, requester i at [26i+25:26i]
//   RSP_VALID/RSP_READY : response handshake
//   RSP_S/RSP_ID        : 27-bit sum and granted requester index
//   BUSY                : arbiter is not idle
interface adder_share_arbiter_if;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 26;
  localparam int unsigned IDW  = 2;

  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ*W-1:0] REQ_X;
  logic [NREQ*W-1:0] REQ_Y;
  logic [NREQ-1:0]   REQ_READY;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [W:0]        RSP_S;
  logic [IDW-1:0]    RSP_ID;
  logic              BUSY;

  modport slave (
    input  REQ_VALID, REQ_X, REQ_Y, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_S, RSP_ID, BUSY
  );

  modport master (
    output REQ_VALID, REQ_X, REQ_Y, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_S, RSP_ID, BUSY
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Four requesters share one 26-bit Brent-Kung adder through a round-robin
// arbiter. A granted operand pair is registered into the adder, the 27-bit
// sum is registered with the winner's ID and held until the consumer accepts.
//   CLK, RSTn : clock, asynchronous active-low reset
//   bus       : adder_share_arbiter_if.slave (request/response handshakes, BUSY)
// Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no last-grant pointer); default is round-robin.

// 26-bit Brent-Kung adder, carry-in 0, 27-bit sum.
module UBBKA_25_0_25_0 (
  input  logic [25:0] X,
  input  logic [25:0] Y,
  output logic [26:0] S
);
  localparam int PW = 32;  // prefix tree span, next power of two above 26

  always_comb begin : prefix
    logic [PW-1:0] gp;
    logic [PW-1:0] pp;
    logic [PW-1:0] p0;
    gp = '0;
    pp = '0;
    p0 = '0;
    gp[25:0] = X & Y;
    pp[25:0] = X ^ Y;
    p0       = pp;
    // Up-sweep: group (G,P) over power-of-two aligned spans.
    for (int d = 0; d < 5; d++) begin
      for (int i = (2 << d) - 1; i < PW; i += (2 << d)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    // Down-sweep: fill in the remaining prefix carries.
    for (int d = 3; d >= 0; d--) begin
      for (int i = (2 << d) - 1 + (1 << d); i < PW; i += (2 << d)) begin
        gp[i] = gp[i] | (pp[i] & gp[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    // gp[i] is the carry out of bit i.
    S = {gp[25], p0[25:0] ^ {gp[24:0], 1'b0}};
  end
endmodule

module adder_share_arbiter (
  input  logic                   CLK,
  input  logic                   RSTn,
  adder_share_arbiter_if.slave   bus
);
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 26;
  localparam int unsigned IDW  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [W:0]      r_rsp_s;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_busy;
`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_idx;
`endif

  logic            w_grant_en;
  logic            w_hs;
  logic [IDW-1:0]  w_id;
  logic [NREQ-1:0] w_grant;
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_y;
  logic [W:0]      w_sum;

  // Grants are offered only when the operand register is free this cycle.
  assign w_grant_en = (r_state == IDLE) || ((r_state == RESP) && bus.RSP_READY);

  // Grant selection over currently valid requesters.
  always_comb begin
    w_hs    = 1'b0;
    w_id    = '0;
    w_grant = '0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.REQ_VALID[k]) begin
        w_hs = 1'b1;
        w_id = IDW'(k);
      end
    end
`else
    w_idx = '0;
    // Search pointer+1 .. pointer+4; the last probe wraps back to the pointer.
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = IDW'(r_ptr + IDW'(k));
      if (!w_hs && bus.REQ_VALID[w_idx]) begin
        w_hs = 1'b1;
        w_id = w_idx;
      end
    end
`endif
    if (!w_grant_en) begin
      w_hs = 1'b0;
    end
    if (w_hs) begin
      w_grant = NREQ'(1) << w_id;
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (w_id == IDW'(k)) begin
        w_x = bus.REQ_X[k*W +: W];
        w_y = bus.REQ_Y[k*W +: W];
      end
    end
  end

  UBBKA_25_0_25_0 u_add (
    .X (r_x),
    .Y (r_y),
    .S (w_sum)
  );

  // Control FSM with registered response path.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      r_ptr       <= IDW'(NREQ - 1);
`endif
    end else begin
      // Accept path is shared by IDLE and RESP-with-release.
      if (w_hs) begin
        r_x     <= w_x;
        r_y     <= w_y;
        r_id    <= w_id;
        r_state <= ADD;
        r_busy  <= 1'b1;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        r_ptr   <= w_id;
`endif
      end
      case (r_state)
        IDLE: begin
        end
        ADD: begin
          r_rsp_s     <= w_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            if (!w_hs) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.REQ_READY = w_grant;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_S     = r_rsp_s;
  assign bus.RSP_ID    = r_rsp_id;
  assign bus.BUSY      = r_busy;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus a
// scoreboard fed at each request handshake and drained at each response accept.
module tb_adder_share_arbiter;
  localparam logic [25:0] MAXV = 26'h3FFFFFF;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  adder_share_arbiter_if bus ();

  adder_share_arbiter dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [26:0] s;
  } exp_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_rsp = 0;
  exp_t       sb_q[$];
  logic [1:0] id_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin : mon
    exp_t e;
    logic [25:0] x;
    logic [25:0] y;
    if (RSTn) begin
      chk("rdy_legal", 32'($onehot0(bus.REQ_READY) &&
                           ((bus.REQ_READY & ~bus.REQ_VALID) == 4'b0)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (bus.REQ_VALID[k] && bus.REQ_READY[k]) begin
          x = bus.REQ_X[k*26 +: 26];
          y = bus.REQ_Y[k*26 +: 26];
          e.id = 2'(k);
          e.s  = 27'(x) + 27'(y);
          sb_q.push_back(e);
        end
      end
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_s", 32'(bus.RSP_S), 32'(e.s));
          chk("rsp_id", 32'(bus.RSP_ID), 32'(e.id));
        end
        id_log.push_back(bus.RSP_ID);
        n_rsp++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [25:0] x, input logic [25:0] y);
    bus.REQ_X[k*26 +: 26] = x;
    bus.REQ_Y[k*26 +: 26] = y;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    bus.REQ_VALID = '0;
    bus.RSP_READY = 1'b0;
    @(negedge CLK);
    sb_q.delete();
    tick();
    RSTn = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (bus.RSP_VALID) seen = 1'b1;
    end
    if (!seen) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    tick();
    bus.REQ_VALID = '0;
    bus.RSP_READY = 1'b1;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge CLK);
      if (!bus.BUSY && !bus.RSP_VALID) idle = 1'b1;
    end
    if (!idle) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_until_log(input int n, input int budget);
    for (int i = 0; i < budget && id_log.size() < n; i++) tick();
  endtask

`ifdef ADDER_ARB_FIXED_PRIO_EN
  int exp_fair[5] = '{0, 0, 0, 0, 0};
  int exp_drop[3] = '{1, 0, 0};
  logic [3:0] exp_rel_grant  = 4'b0001;
  logic [3:0] exp_drop_grant = 4'b0001;
`else
  int exp_fair[5] = '{0, 1, 2, 3, 0};
  int exp_drop[3] = '{1, 3, 0};
  logic [3:0] exp_rel_grant  = 4'b0010;
  logic [3:0] exp_drop_grant = 4'b1000;
`endif

  initial begin
    logic [25:0] x0, y0;
    int n0;
    RSTn = 1'b0;
    bus.REQ_VALID = '0;
    bus.REQ_X = '0;
    bus.REQ_Y = '0;
    bus.RSP_READY = 1'b0;

    // Reset values.
    repeat (2) @(negedge CLK);
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_rsp_s", 32'(bus.RSP_S), 32'd0);
    chk("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    tick();
    RSTn = 1'b1;

    // Carry out of the top bit, latency of two edges.
    set_ops(0, MAXV, 26'h0000001);
    bus.REQ_VALID = 4'b0001;
    @(negedge CLK);
    chk("t1_grant", 32'(bus.REQ_READY), 32'h1);
    tick();
    bus.REQ_VALID = 4'b0000;
    @(negedge CLK);
    chk("t1_add_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("t1_add_busy", 32'(bus.BUSY), 32'd1);
    chk("t1_add_ready", 32'(bus.REQ_READY), 32'd0);
    tick();
    @(negedge CLK);
    chk("t1_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    chk("t1_rsp_s", 32'(bus.RSP_S), 32'h4000000);
    chk("t1_rsp_id", 32'(bus.RSP_ID), 32'd0);
    tick();
    bus.RSP_READY = 1'b1;
    tick();
    @(negedge CLK);
    chk("t1_idle_busy", 32'(bus.BUSY), 32'd0);
    chk("t1_idle_valid", 32'(bus.RSP_VALID), 32'd0);

    // Fairness with all four continuously valid.
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, 26'($urandom), 26'($urandom));
    bus.REQ_VALID = 4'b1111;
    bus.RSP_READY = 1'b1;
    id_log.delete();
    run_until_log(5, 40);
    chk("t2_count", 32'(id_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < id_log.size()) chk("t2_order", 32'(id_log[i]), 32'(exp_fair[i]));
    drain();

    // Backpressure holds the response; release accepts in the same cycle.
    do_reset();
    x0 = 26'($urandom);
    y0 = 26'($urandom);
    set_ops(0, x0, y0);
    set_ops(1, 26'($urandom), 26'($urandom));
    bus.REQ_VALID = 4'b0011;
    bus.RSP_READY = 1'b0;
    wait_rsp("t3_timeout", 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      chk("t3_hold_valid", 32'(bus.RSP_VALID), 32'd1);
      chk("t3_hold_s", 32'(bus.RSP_S), 32'(27'(x0) + 27'(y0)));
      chk("t3_hold_id", 32'(bus.RSP_ID), 32'd0);
      chk("t3_hold_ready", 32'(bus.REQ_READY), 32'd0);
    end
    @(posedge CLK);
    #1;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    chk("t3_release_grant", 32'(bus.REQ_READY), 32'(exp_rel_grant));
    @(negedge CLK);
    chk("t3_gap_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("t3_gap_busy", 32'(bus.BUSY), 32'd1);
    drain();

    // Requester 2 raises then drops while requester 1 is serviced.
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, 26'($urandom), 26'($urandom));
    id_log.delete();
    bus.REQ_VALID = 4'b0010;
    bus.RSP_READY = 1'b0;
    @(negedge CLK);
    chk("t4_grant1", 32'(bus.REQ_READY), 32'h2);
    tick();
    bus.REQ_VALID = 4'b0100;
    tick();
    bus.REQ_VALID = 4'b0000;
    tick();
    bus.REQ_VALID = 4'b1001;
    tick();
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    chk("t4_grant_next", 32'(bus.REQ_READY), 32'(exp_drop_grant));
    run_until_log(3, 20);
    chk("t4_count", 32'(id_log.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < id_log.size()) chk("t4_order", 32'(id_log[i]), 32'(exp_drop[i]));
    drain();

    // Reset while in ADD discards the pair and restores the pointer.
    do_reset();
    set_ops(2, 26'($urandom), 26'($urandom));
    bus.REQ_VALID = 4'b0100;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    chk("t5_grant2", 32'(bus.REQ_READY), 32'h4);
    tick();
    RSTn = 1'b0;
    bus.REQ_VALID = 4'b0000;
    @(negedge CLK);
    sb_q.delete();
    chk("t5_rst_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("t5_rst_busy", 32'(bus.BUSY), 32'd0);
    tick();
    RSTn = 1'b1;
    for (int k = 0; k < 4; k++) set_ops(k, 26'($urandom), 26'($urandom));
    bus.REQ_VALID = 4'b1111;
    @(negedge CLK);
    chk("t5_idle_busy", 32'(bus.BUSY), 32'd0);
    chk("t5_first_grant", 32'(bus.REQ_READY), 32'h1);
    drain();

    // Maximum operands, then random traffic through the scoreboard.
    do_reset();
    set_ops(3, MAXV, MAXV);
    bus.REQ_VALID = 4'b1000;
    bus.RSP_READY = 1'b1;
    wait_rsp("t6_timeout", 20);
    chk("t6_max_s", 32'(bus.RSP_S), 32'h7FFFFFE);
    chk("t6_max_id", 32'(bus.RSP_ID), 32'd3);
    tick();
    n0 = n_rsp;
    for (int c = 0; c < 8000 && (n_rsp - n0) < 1000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) set_ops(k, MAXV, MAXV);
        else set_ops(k, 26'($urandom), 26'($urandom));
      end
      bus.REQ_VALID = 4'($urandom);
      bus.RSP_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("t6_count", 32'((n_rsp - n0) >= 1000), 32'd1);
    drain();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one 26-bit Brent-Kung adder instance (`UBBKA_25_0_25_0`, 27-bit sum, carry-in tied 0) among four requesters. Each requester offers an operand pair through a valid/ready handshake. A round-robin arbiter grants one pair at a time, registers the operands into the adder and registers the 27-bit sum with the winner's ID. The sum is held on a response port until accepted. The block sits between the requesting engines and the shared adder datapath.

## Interface
- `NREQ`, 4, number of requesters (fixed at 4; ID is 2 bits)
- `W`, 26, operand width (fixed to match the adder; sum is W+1)
- `CLK` in 1, rising-edge clock
- `RSTn` in 1, asynchronous active-low reset
- `REQ_VALID` in 4, bit i: requester i offers an operand pair
- `REQ_X` in 104, requester i operand X at [26i+25:26i]
- `REQ_Y` in 104, requester i operand Y at [26i+25:26i]
- `REQ_READY` out 4, one-hot grant; pair i is accepted when REQ_VALID[i] & REQ_READY[i]
- `RSP_VALID` out 1, response holds a valid sum
- `RSP_READY` in 1, consumer accepts the response
- `RSP_S` out 27, X+Y of the granted pair
- `RSP_ID` out 2, index of the granted requester
- `BUSY` out 1, high in every state except IDLE

## Operation
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_S=0, RSP_ID=0, BUSY=0, state=IDLE, last-grant pointer=3 (requester 0 wins the first tie).
- FSM states: IDLE, ADD, RESP.
- IDLE: REQ_READY is the combinational round-robin grant over REQ_VALID. Search starts at pointer+1 and wraps modulo 4.
  - On any handshake: latch X, Y and ID into the operand register, set pointer=ID, go to ADD.
  - With no valid request: stay in IDLE.
- ADD: REQ_READY=0.
  - Register the adder output into RSP_S and the latched ID into RSP_ID.
  - Set RSP_VALID=1 and go to RESP.
- RESP: RSP_VALID=1; RSP_S and RSP_ID are stable.
  - On RSP_READY=1 with any REQ_VALID: REQ_READY drives the round-robin grant and a new pair is accepted in the same cycle. Go to ADD; RSP_VALID drops for one cycle.
  - On RSP_READY=1 with no REQ_VALID: REQ_READY=0, go to IDLE, RSP_VALID=0.
  - On RSP_READY=0: REQ_READY=0, hold.
- Arithmetic: RSP_S = {1'b0,X} + {1'b0,Y}, full 27 bits, no truncation or saturation. Carry-in is always 0.
- REQ_READY is never asserted for a requester whose REQ_VALID is 0. At most one bit is set.
- A requester may drop REQ_VALID before a grant. A dropped request is simply not granted, and no state is affected.
- Reset asserted mid-operation: all state returns to the reset values immediately, and any in-flight pair or response is discarded.

## Timing
- Latency: handshake at edge N, RSP_VALID=1 from edge N+2 (one cycle in ADD).
- Throughput: one result per 2 cycles when RSP_READY is held at 1 and requests are continuous.
- The adder path is operand register to RSP_S register, a full cycle.
- REQ_READY depends combinationally on REQ_VALID, state, pointer and RSP_READY. No other output is combinational.
- Fairness: with all four requesters continuously valid, grants follow the order 0,1,2,3,0,…

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN`
- Defined: fixed priority. The lowest index wins. The pointer register is removed and is not updated.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then REQ_VALID=4'b0001 with X=0x3FFFFFF, Y=0x0000001 → grant to 0 at edge 1. RSP_VALID at edge 3 with RSP_S=0x4000000 and RSP_ID=0.
- All four valid continuously, RSP_READY=1 → RSP_ID sequence 0,1,2,3,0. With `ADDER_ARB_FIXED_PRIO_EN`: sequence 0,0,0.
- Backpressure: RSP_READY=0 for 5 cycles with a response pending → RSP_S, RSP_ID and RSP_VALID unchanged and REQ_READY=0. Release → the next pair is accepted in the same cycle.
- Requester 2 drops REQ_VALID while requester 1 is being serviced → requester 2 is never granted and the pointer is unaffected by requester 2.
- RSTn pulsed low while in ADD → next cycle RSP_VALID=0, BUSY=0, state IDLE. The first subsequent grant goes to requester 0.
- Random operand pairs (1000) → every RSP_S equals the 27-bit reference sum, including X=Y=0x3FFFFFF → 0x7FFFFFE.
